// File: rtl/pin_collision.sv
// Ball-vs-pin collision scan: latches one frame of ball/pin state, resolves the 10 pins
// through a two-stage distance pipeline and pulses valid_out when all pin outputs are coherent.
module pin_collision #(
  parameter int HIT_RADIUS     = 24,
  parameter int TRANSFER_SHIFT = 1,
  parameter int SCREEN_WIDTH   = 1024,
  parameter int SCREEN_HEIGHT  = 768
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              clear_in,
  input  logic [10:0]       ball_x_in,
  input  logic [9:0]        ball_y_in,
  input  logic [15:0]       ball_vx_in,
  input  logic [15:0]       ball_vy_in,
  input  logic [9:0][10:0]  pins_x_in,
  input  logic [9:0][9:0]   pins_y_in,
  input  logic [9:0][15:0]  pins_vx_in,
  input  logic [9:0][15:0]  pins_vy_in,
  output logic [9:0][15:0]  pins_vx_out,
  output logic [9:0][15:0]  pins_vy_out,
  output logic [9:0]        pins_hit_out,
  output logic              valid_out,
  output logic              busy_out,
  output logic [1:0]        state_out
);

  // Handshake: start_in is a single-cycle request accepted only in IDLE (busy_out=0);
  // valid_out is a single-cycle pulse with no back-pressure, outputs stay held afterwards.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [24:0] R2    = 25'(HIT_RADIUS * HIT_RADIUS);
  localparam logic [10:0] X_LIM = 11'(SCREEN_WIDTH);
  localparam logic [9:0]  Y_LIM = 10'(SCREEN_HEIGHT);

  state_t state_q, state_d;
  logic [3:0] idx_q;

  logic [10:0]        ball_x_q;
  logic [9:0]         ball_y_q;
  logic signed [15:0] ball_vx_q;
  logic signed [15:0] ball_vy_q;
  logic [9:0][10:0]   pins_x_q;
  logic [9:0][9:0]    pins_y_q;
  logic [9:0][15:0]   pins_vx_q;
  logic [9:0][15:0]   pins_vy_q;

  logic               s1_valid;
  logic [3:0]         s1_idx;
  logic signed [11:0] s1_dx;
  logic signed [10:0] s1_dy;
  logic               s1_on;

  logic signed [23:0] dx_ext, dx_sq;
  logic signed [21:0] dy_ext, dy_sq;
  logic [24:0]        d2;
  logic               hit_now;
  logic               ball_on;
  logic               accept;
  logic               clear_ok;

  assign accept   = (state_q == IDLE) && start_in;
  assign clear_ok = (state_q == IDLE) && clear_in;
  assign ball_on  = (ball_x_q < X_LIM) && (ball_y_q < Y_LIM);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = SCAN;
      SCAN:    if (idx_q == 4'd9) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign valid_out = (state_q == DONE);
  assign busy_out  = (state_q != IDLE);
  assign state_out = state_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx_q <= '0;
    end else if (state_q == SCAN && idx_q != 4'd9) begin
      idx_q <= idx_q + 4'd1;
    end else begin
      idx_q <= '0;
    end
  end

  // Shadow copies: everything downstream reads only these, so inputs may move mid-scan.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ball_x_q  <= '0;
      ball_y_q  <= '0;
      ball_vx_q <= '0;
      ball_vy_q <= '0;
      pins_x_q  <= '0;
      pins_y_q  <= '0;
      pins_vx_q <= '0;
      pins_vy_q <= '0;
    end else if (accept) begin
      ball_x_q  <= ball_x_in;
      ball_y_q  <= ball_y_in;
      ball_vx_q <= ball_vx_in;
      ball_vy_q <= ball_vy_in;
      pins_x_q  <= pins_x_in;
      pins_y_q  <= pins_y_in;
      pins_vx_q <= pins_vx_in;
      pins_vy_q <= pins_vy_in;
    end
  end

  // Stage 1: one extra sign bit keeps the differences exact over the full input range.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_on    <= 1'b0;
    end else begin
      s1_valid <= (state_q == SCAN);
      s1_idx   <= idx_q;
      s1_dx    <= $signed({1'b0, ball_x_q}) - $signed({1'b0, pins_x_q[idx_q]});
      s1_dy    <= $signed({1'b0, ball_y_q}) - $signed({1'b0, pins_y_q[idx_q]});
      s1_on    <= ball_on && (pins_x_q[idx_q] < X_LIM) && (pins_y_q[idx_q] < Y_LIM);
    end
  end

  assign dx_ext  = 24'(s1_dx);
  assign dy_ext  = 22'(s1_dy);
  assign dx_sq   = dx_ext * dx_ext;
  assign dy_sq   = dy_ext * dy_ext;
  assign d2      = 25'($unsigned(dx_sq)) + 25'($unsigned(dy_sq));
  assign hit_now = s1_on && (d2 <= R2);

  // Stage 2: write back one pin; clear only reaches here while idle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pins_hit_out <= '0;
      pins_vx_out  <= '0;
      pins_vy_out  <= '0;
    end else if (clear_ok) begin
      pins_hit_out <= '0;
      pins_vx_out  <= '0;
      pins_vy_out  <= '0;
    end else if (s1_valid) begin
      if (pins_hit_out[s1_idx]) begin
        pins_vx_out[s1_idx] <= pins_vx_q[s1_idx];
        pins_vy_out[s1_idx] <= pins_vy_q[s1_idx];
      end else if (hit_now) begin
        pins_hit_out[s1_idx] <= 1'b1;
        pins_vx_out[s1_idx]  <= ball_vx_q >>> TRANSFER_SHIFT;
        pins_vy_out[s1_idx]  <= ball_vy_q >>> TRANSFER_SHIFT;
      end else begin
        pins_vx_out[s1_idx] <= '0;
        pins_vy_out[s1_idx] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pin_collision.sv
// Bench for pin_collision: directed rack scenarios plus randomized frames, scored against
// a distance-rule model of the collision stage.
module tb_pin_collision;

  logic              clk_in = 1'b0;
  logic              rst_in, start_in, clear_in;
  logic [10:0]       ball_x_in;
  logic [9:0]        ball_y_in;
  logic [15:0]       ball_vx_in, ball_vy_in;
  logic [9:0][10:0]  pins_x_in;
  logic [9:0][9:0]   pins_y_in;
  logic [9:0][15:0]  pins_vx_in, pins_vy_in;
  logic [9:0][15:0]  pins_vx_out, pins_vy_out;
  logic [9:0]        pins_hit_out;
  logic              valid_out, busy_out;
  logic [1:0]        state_out;

  pin_collision dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .clear_in(clear_in),
    .ball_x_in(ball_x_in), .ball_y_in(ball_y_in),
    .ball_vx_in(ball_vx_in), .ball_vy_in(ball_vy_in),
    .pins_x_in(pins_x_in), .pins_y_in(pins_y_in),
    .pins_vx_in(pins_vx_in), .pins_vy_in(pins_vy_in),
    .pins_vx_out(pins_vx_out), .pins_vy_out(pins_vy_out),
    .pins_hit_out(pins_hit_out), .valid_out(valid_out), .busy_out(busy_out),
    .state_out(state_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // reference model state
  bit          ref_hit[10];
  logic [15:0] ref_vx[10];
  logic [15:0] ref_vy[10];

  // scoreboard
  logic [9:0]       exp_hit_q[$];
  logic [9:0][15:0] exp_vx_q[$];
  logic [9:0][15:0] exp_vy_q[$];
  int               exp_cyc_q[$];

  function automatic logic [15:0] half_floor(input logic [15:0] v);
    int s;
    s = $signed(v);
    s = (s - (s & 1)) / 2;
    return 16'(s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 10; i++) begin
      ref_hit[i] = 1'b0;
      ref_vx[i]  = '0;
      ref_vy[i]  = '0;
    end
  endtask

  task automatic model_scan(input int due);
    logic [9:0]       h;
    logic [9:0][15:0] vx, vy;
    for (int i = 0; i < 10; i++) begin
      int dx, dy, d2;
      bit on;
      dx = int'(ball_x_in) - int'(pins_x_in[i]);
      dy = int'(ball_y_in) - int'(pins_y_in[i]);
      d2 = dx * dx + dy * dy;
      on = (ball_x_in < 1024) && (ball_y_in < 768) && (pins_x_in[i] < 1024) && (pins_y_in[i] < 768);
      if (ref_hit[i]) begin
        ref_vx[i] = pins_vx_in[i];
        ref_vy[i] = pins_vy_in[i];
      end else if (on && d2 <= 24 * 24) begin
        ref_hit[i] = 1'b1;
        ref_vx[i]  = half_floor(ball_vx_in);
        ref_vy[i]  = half_floor(ball_vy_in);
      end else begin
        ref_vx[i] = '0;
        ref_vy[i] = '0;
      end
      h[i] = ref_hit[i];
      vx[i] = ref_vx[i];
      vy[i] = ref_vy[i];
    end
    exp_hit_q.push_back(h);
    exp_vx_q.push_back(vx);
    exp_vy_q.push_back(vy);
    exp_cyc_q.push_back(due);
  endtask

  // monitor
  always @(negedge clk_in) begin
    if (valid_out) begin
      valid_cnt++;
      if (exp_hit_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid_out=1 at cycle %0d want no pulse", cyc);
      end else begin
        check("valid_latency", 160'(cyc), 160'(exp_cyc_q.pop_front()));
        check("hit_out", 160'(pins_hit_out), 160'(exp_hit_q.pop_front()));
        check("vx_out", pins_vx_out, exp_vx_q.pop_front());
        check("vy_out", pins_vy_out, exp_vy_q.pop_front());
      end
    end
  end

  // drivers
  task automatic set_rack();
    for (int i = 0; i < 9; i++) begin
      pins_x_in[i] = 11'(300 + 40 * i);
      pins_y_in[i] = 10'd100;
    end
    pins_x_in[9] = 11'd144;
    pins_y_in[9] = 10'd180;
    pins_vx_in = '0;
    pins_vy_in = '0;
  endtask

  task automatic set_ball(input int x, input int y, input logic [15:0] vx, input logic [15:0] vy);
    ball_x_in  = 11'(x);
    ball_y_in  = 10'(y);
    ball_vx_in = vx;
    ball_vy_in = vy;
  endtask

  task automatic scramble_inputs();
    ball_x_in  = 11'($urandom);
    ball_y_in  = 10'($urandom);
    ball_vx_in = 16'($urandom);
    ball_vy_in = 16'($urandom);
    for (int i = 0; i < 10; i++) begin
      pins_x_in[i]  = 11'($urandom);
      pins_y_in[i]  = 10'($urandom);
      pins_vx_in[i] = 16'($urandom);
      pins_vy_in[i] = 16'($urandom);
    end
  endtask

  // Entered and left at posedge+#1; start_in is high for cycle C.
  task automatic run_scan(input bit with_clear, input bit poke_busy, input bit scramble);
    int c0;
    c0 = cyc;
    if (with_clear) model_clear();
    model_scan(c0 + 12);
    start_in = 1'b1;
    clear_in = with_clear;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    clear_in = 1'b0;
    if (scramble) scramble_inputs();
    @(negedge clk_in);
    check("busy_at_c1", 160'(busy_out), 160'(1));
    for (int j = 2; j <= 13; j++) begin
      @(posedge clk_in); #1;
      start_in = poke_busy && (j == 5);
      clear_in = poke_busy && (j == 7);
      if (scramble) scramble_inputs();
    end
    @(negedge clk_in);
    check("busy_at_c13", 160'(busy_out), 160'(0));
    if (exp_hit_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout: got no valid_out by cycle %0d want pulse at %0d", cyc, c0 + 12);
      exp_hit_q.delete();
      exp_vx_q.delete();
      exp_vy_q.delete();
      exp_cyc_q.delete();
    end
    @(posedge clk_in); #1;
  endtask

  task automatic do_clear();
    clear_in = 1'b1;
    @(posedge clk_in); #1;
    clear_in = 1'b0;
    model_clear();
    @(negedge clk_in);
    check("clear_hit", 160'(pins_hit_out), 160'(0));
    check("clear_vx", pins_vx_out, 160'(0));
    check("clear_vy", pins_vy_out, 160'(0));
    @(posedge clk_in); #1;
  endtask

  task automatic reset_mid_scan();
    int v0;
    v0 = valid_cnt;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    model_clear();
    #1;
    check("rst_mid_hit", 160'(pins_hit_out), 160'(0));
    check("rst_mid_vx", pins_vx_out, 160'(0));
    check("rst_mid_busy", 160'(busy_out), 160'(0));
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    check("rst_no_valid", 160'(valid_cnt), 160'(v0));
    check("rst_after_vy", pins_vy_out, 160'(0));
  endtask

  initial begin
    int v0;
    rst_in = 1'b1;
    start_in = 1'b0;
    clear_in = 1'b0;
    set_ball(0, 0, 16'h0, 16'h0);
    set_rack();
    model_clear();
    #1;
    check("reset_hit", 160'(pins_hit_out), 160'(0));
    check("reset_vx", pins_vx_out, 160'(0));
    check("reset_vy", pins_vy_out, 160'(0));
    check("reset_valid_busy", 160'({valid_out, busy_out, state_out}), 160'(0));
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // rack, ball well below: nothing hit
    set_ball(144, 300, 16'h0000, 16'hFFF8);
    run_scan(0, 0, 0);
    check("case1_hit", 160'(pins_hit_out), 160'(0));

    // ball on pin 9
    set_ball(150, 180, 16'h0004, 16'hFFEC);
    run_scan(0, 0, 0);
    check("case2_hit", 160'(pins_hit_out), 160'(10'h200));
    check("case2_vx9", 160'(pins_vx_out[9]), 160'(16'h0002));
    check("case2_vy9", 160'(pins_vy_out[9]), 160'(16'hFFF6));

    // sticky hit keeps pin velocity fed back
    set_ball(500, 600, 16'h0004, 16'hFFEC);
    pins_vx_in[9] = 16'd7;
    pins_vy_in[9] = 16'd3;
    run_scan(0, 0, 0);
    check("case4_hit", 160'(pins_hit_out), 160'(10'h200));
    check("case4_vx9", 160'(pins_vx_out[9]), 160'(16'd7));

    // exact contact radius and one pixel past it
    do_clear();
    set_rack();
    pins_x_in[0] = 11'd200;
    pins_y_in[0] = 10'd200;
    set_ball(224, 200, 16'h0010, 16'h0010);
    run_scan(0, 0, 0);
    check("edge_exact_hit", 160'(pins_hit_out[0]), 160'(1));
    do_clear();
    set_ball(224, 201, 16'h0010, 16'h0010);
    run_scan(0, 0, 0);
    check("edge_over_hit", 160'(pins_hit_out[0]), 160'(0));

    // off-screen pin overlapping the ball; extra start/clear while busy
    do_clear();
    set_rack();
    pins_x_in[0] = 11'd1024;
    pins_y_in[0] = 10'd200;
    set_ball(1010, 200, 16'h0020, 16'h0020);
    v0 = valid_cnt;
    run_scan(0, 1, 0);
    check("offscreen_hit", 160'(pins_hit_out), 160'(0));
    check("busy_start_one_valid", 160'(valid_cnt), 160'(v0 + 1));

    // reset in the middle of a scan that would hit
    set_rack();
    set_ball(150, 180, 16'h0004, 16'hFFEC);
    run_scan(0, 0, 0);
    reset_mid_scan();

    // clear and start in the same cycle
    set_ball(150, 180, 16'h0004, 16'hFFEC);
    run_scan(0, 0, 0);
    pins_vx_in[9] = 16'd7;
    set_ball(140, 176, 16'hFFF3, 16'h0009);
    run_scan(1, 0, 0);
    check("clear_start_vx9", 160'(pins_vx_out[9]), 160'(16'hFFF9));

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      int j;
      for (int i = 0; i < 10; i++) begin
        pins_x_in[i]  = 11'($urandom_range(40, 1100));
        pins_y_in[i]  = 10'($urandom_range(40, 800));
        pins_vx_in[i] = 16'($urandom);
        pins_vy_in[i] = 16'($urandom);
      end
      j = $urandom_range(0, 9);
      set_ball(int'(pins_x_in[j]) + $urandom_range(0, 60) - 30,
               int'(pins_y_in[j]) + $urandom_range(0, 60) - 30,
               16'($urandom), 16'($urandom));
      run_scan($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    check("queue_drained", 160'(exp_hit_q.size()), 160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
